// File: rtl/btrfly_ifft16_if.sv
// Handshake and data bundle for the inverse radix-2 butterfly.
// Member names keep the i_/o_ prefixes as seen from the butterfly side.
interface btrfly_ifft16_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         i_valid_btrfly_ifft16;
    logic                         o_ready_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_a_real_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_a_imag_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_b_real_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_b_imag_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_w_real_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] i_w_imag_btrfly_ifft16;
    logic                         o_valid_btrfly_ifft16;
    logic                         i_ready_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] o_sum_real_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] o_sum_imag_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] o_diff_real_btrfly_ifft16;
    logic signed [DATA_WIDTH-1:0] o_diff_imag_btrfly_ifft16;
    logic                         i_ovf_clr_btrfly_ifft16;
    logic                         o_ovf_btrfly_ifft16;

    // Butterfly side
    modport slave (
        input  i_valid_btrfly_ifft16,
        output o_ready_btrfly_ifft16,
        input  i_a_real_btrfly_ifft16, i_a_imag_btrfly_ifft16,
        input  i_b_real_btrfly_ifft16, i_b_imag_btrfly_ifft16,
        input  i_w_real_btrfly_ifft16, i_w_imag_btrfly_ifft16,
        output o_valid_btrfly_ifft16,
        input  i_ready_btrfly_ifft16,
        output o_sum_real_btrfly_ifft16, o_sum_imag_btrfly_ifft16,
        output o_diff_real_btrfly_ifft16, o_diff_imag_btrfly_ifft16,
        input  i_ovf_clr_btrfly_ifft16,
        output o_ovf_btrfly_ifft16
    );

    // Driver / consumer side
    modport master (
        output i_valid_btrfly_ifft16,
        input  o_ready_btrfly_ifft16,
        output i_a_real_btrfly_ifft16, i_a_imag_btrfly_ifft16,
        output i_b_real_btrfly_ifft16, i_b_imag_btrfly_ifft16,
        output i_w_real_btrfly_ifft16, i_w_imag_btrfly_ifft16,
        input  o_valid_btrfly_ifft16,
        output i_ready_btrfly_ifft16,
        input  o_sum_real_btrfly_ifft16, o_sum_imag_btrfly_ifft16,
        input  o_diff_real_btrfly_ifft16, o_diff_imag_btrfly_ifft16,
        output i_ovf_clr_btrfly_ifft16,
        input  o_ovf_btrfly_ifft16
    );
endinterface

// File: rtl/btrfly_ifft16.sv
// Radix-2 DIF inverse butterfly for the TX 16-point IFFT.
// sum = (a+b)/2, diff = ((a-b)*conj(W))/2, three pipeline stages,
// round-half-up, per-result saturation, sticky overflow flag.
// W is the forward twiddle; it is conjugated here so TX and RX share one ROM.
module btrfly_ifft16 #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 12,
    parameter int INT_WIDTH  = 4
) (
    input  logic            i_clk_btrfly_ifft16,
    input  logic            i_rst_btrfly_ifft16,
    btrfly_ifft16_if.slave  bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int OUT_W = INT_WIDTH + FRAC_WIDTH;
    localparam int PW    = 2 * DW + 3;

    // Representable output range and rounding constants, at the widest path width
    localparam logic signed [PW-1:0] SAT_MAX   = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic signed [PW-1:0] SUM_RND   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] DIFF_RND  = {{(PW-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};

    function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] x);
        if (x > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return x[DW-1:0];
    endfunction

    function automatic logic clips(input logic signed [PW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    logic en;

    // Stage 1 registers
    logic                 v1;
    logic signed [DW:0]   s1_sr, s1_si, s1_dr, s1_di;
    logic signed [DW-1:0] s1_wr, s1_wi;

    // Stage 2 registers
    logic                   v2;
    logic signed [DW:0]     s2_sr, s2_si;
    logic signed [2*DW+1:0] s2_pr, s2_pi;

    // Stage 3 rounding/saturation results
    logic signed [PW-1:0] x_sr, x_si, x_dr, x_di;
    logic                 ovf_hit;

    // Whole pipeline advances together; ready is the advance enable
    always_comb begin
        en = !bus.o_valid_btrfly_ifft16 || bus.i_ready_btrfly_ifft16;
        bus.o_ready_btrfly_ifft16 = en;
    end

    // Stage 1: widened sum and difference, twiddle carried alongside
    always_ff @(posedge i_clk_btrfly_ifft16) begin
        if (i_rst_btrfly_ifft16) begin
            v1    <= 1'b0;
            s1_sr <= '0;
            s1_si <= '0;
            s1_dr <= '0;
            s1_di <= '0;
            s1_wr <= '0;
            s1_wi <= '0;
        end else if (en) begin
            v1    <= bus.i_valid_btrfly_ifft16;
            s1_sr <= {bus.i_a_real_btrfly_ifft16[DW-1], bus.i_a_real_btrfly_ifft16}
                   + {bus.i_b_real_btrfly_ifft16[DW-1], bus.i_b_real_btrfly_ifft16};
            s1_si <= {bus.i_a_imag_btrfly_ifft16[DW-1], bus.i_a_imag_btrfly_ifft16}
                   + {bus.i_b_imag_btrfly_ifft16[DW-1], bus.i_b_imag_btrfly_ifft16};
            s1_dr <= {bus.i_a_real_btrfly_ifft16[DW-1], bus.i_a_real_btrfly_ifft16}
                   - {bus.i_b_real_btrfly_ifft16[DW-1], bus.i_b_real_btrfly_ifft16};
            s1_di <= {bus.i_a_imag_btrfly_ifft16[DW-1], bus.i_a_imag_btrfly_ifft16}
                   - {bus.i_b_imag_btrfly_ifft16[DW-1], bus.i_b_imag_btrfly_ifft16};
            s1_wr <= bus.i_w_real_btrfly_ifft16;
            s1_wi <= bus.i_w_imag_btrfly_ifft16;
        end
    end

    // Stage 2: full-precision multiply by conj(W), sum path delayed
    always_ff @(posedge i_clk_btrfly_ifft16) begin
        if (i_rst_btrfly_ifft16) begin
            v2    <= 1'b0;
            s2_sr <= '0;
            s2_si <= '0;
            s2_pr <= '0;
            s2_pi <= '0;
        end else if (en) begin
            v2    <= v1;
            s2_sr <= s1_sr;
            s2_si <= s1_si;
            s2_pr <= s1_dr * s1_wr + s1_di * s1_wi;
            s2_pi <= s1_di * s1_wr - s1_dr * s1_wi;
        end
    end

    // Stage 3 datapath: round-half-up scaling at full width, then range test
    always_comb begin
        x_sr = ($signed({{(PW-DW-1){s2_sr[DW]}}, s2_sr}) + SUM_RND) >>> 1;
        x_si = ($signed({{(PW-DW-1){s2_si[DW]}}, s2_si}) + SUM_RND) >>> 1;
        x_dr = ($signed({s2_pr[2*DW+1], s2_pr}) + DIFF_RND) >>> (FRAC_WIDTH + 1);
        x_di = ($signed({s2_pi[2*DW+1], s2_pi}) + DIFF_RND) >>> (FRAC_WIDTH + 1);
        ovf_hit = v2 && (clips(x_sr) || clips(x_si) || clips(x_dr) || clips(x_di));
    end

    // Stage 3: saturated output registers and sticky overflow (set beats clear)
    always_ff @(posedge i_clk_btrfly_ifft16) begin
        if (i_rst_btrfly_ifft16) begin
            bus.o_valid_btrfly_ifft16     <= 1'b0;
            bus.o_sum_real_btrfly_ifft16  <= '0;
            bus.o_sum_imag_btrfly_ifft16  <= '0;
            bus.o_diff_real_btrfly_ifft16 <= '0;
            bus.o_diff_imag_btrfly_ifft16 <= '0;
            bus.o_ovf_btrfly_ifft16       <= 1'b0;
        end else begin
            if (en) begin
                bus.o_valid_btrfly_ifft16     <= v2;
                bus.o_sum_real_btrfly_ifft16  <= sat(x_sr);
                bus.o_sum_imag_btrfly_ifft16  <= sat(x_si);
                bus.o_diff_real_btrfly_ifft16 <= sat(x_dr);
                bus.o_diff_imag_btrfly_ifft16 <= sat(x_di);
            end
            if (en && ovf_hit)
                bus.o_ovf_btrfly_ifft16 <= 1'b1;
            else if (bus.i_ovf_clr_btrfly_ifft16)
                bus.o_ovf_btrfly_ifft16 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_btrfly_ifft16.sv
// Directed bench for btrfly_ifft16: reset state, basic/conjugate/rounding
// vectors, saturation with sticky flag, backpressure stream, mid-stream reset.
module tb_btrfly_ifft16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btrfly_ifft16_if #(.DATA_WIDTH(DW)) bus ();

    btrfly_ifft16 #(.DATA_WIDTH(DW), .FRAC_WIDTH(12), .INT_WIDTH(4)) dut (
        .i_clk_btrfly_ifft16 (clk),
        .i_rst_btrfly_ifft16 (rst),
        .bus                 (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.o_sum_real_btrfly_ifft16, bus.o_sum_imag_btrfly_ifft16,
                bus.o_diff_real_btrfly_ifft16, bus.o_diff_imag_btrfly_ifft16};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi,
                         input logic [15:0] wr, input logic [15:0] wi);
        bus.i_valid_btrfly_ifft16  = v;
        bus.i_a_real_btrfly_ifft16 = ar;
        bus.i_a_imag_btrfly_ifft16 = ai;
        bus.i_b_real_btrfly_ifft16 = br;
        bus.i_b_imag_btrfly_ifft16 = bi;
        bus.i_w_real_btrfly_ifft16 = wr;
        bus.i_w_imag_btrfly_ifft16 = wi;
    endtask

    // One isolated pair: o_valid must appear exactly on the third edge
    task automatic send_check(input string tag,
                              input logic [15:0] ar, input logic [15:0] ai,
                              input logic [15:0] br, input logic [15:0] bi,
                              input logic [15:0] wr, input logic [15:0] wi,
                              input logic [63:0] exp, input logic exp_ovf);
        bus.i_ready_btrfly_ifft16 = 1'b1;
        drive(1'b1, ar, ai, br, bi, wr, wi);
        tick();
        bus.i_valid_btrfly_ifft16 = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(bus.o_valid_btrfly_ifft16), 64'd0);
        tick();
        chk({tag, "_lat2_valid"}, 64'(bus.o_valid_btrfly_ifft16), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(bus.o_valid_btrfly_ifft16), 64'd1);
        chk({tag, "_data"}, outs(), exp);
        chk({tag, "_ovf"}, 64'(bus.o_ovf_btrfly_ifft16), 64'(exp_ovf));
    endtask

    // Backpressure stream model: a=(0x100*(k+1), -0x40*k), b=0, W=1.0
    function automatic logic [63:0] bp_exp(input int k);
        logic [15:0] r, i;
        r = 16'((k + 1) * 128);
        i = 16'(-(k * 32));
        return {r, i, r, i};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx_in;
        int idx_out;
        logic [63:0] held;

        rst = 1'b1;
        bus.i_ready_btrfly_ifft16   = 1'b1;
        bus.i_ovf_clr_btrfly_ifft16 = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.o_valid_btrfly_ifft16), 64'd0);
        chk("rst_ovf",   64'(bus.o_ovf_btrfly_ifft16),   64'd0);
        chk("rst_data",  outs(), 64'd0);
        chk("rst_ready", 64'(bus.o_ready_btrfly_ifft16), 64'd1);

        send_check("basic", 16'h0800, 16'h0000, 16'h0400, 16'h0000, 16'h1000, 16'h0000,
                   {16'h0600, 16'h0000, 16'h0200, 16'h0000}, 1'b0);
        send_check("conj",  16'h0800, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 16'hF000,
                   {16'h0400, 16'h0400, 16'h0400, 16'h0400}, 1'b0);
        send_check("round", 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h1000, 16'h0000,
                   {16'h0001, 16'h0000, 16'h0001, 16'h0000}, 1'b0);
        send_check("sat_pos", 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h2000, 16'h0000,
                   {16'h0000, 16'h0000, 16'h7FFF, 16'h0000}, 1'b1);
        send_check("sticky", 16'h0800, 16'h0000, 16'h0400, 16'h0000, 16'h1000, 16'h0000,
                   {16'h0600, 16'h0000, 16'h0200, 16'h0000}, 1'b1);
        send_check("sat_neg", 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h2000, 16'h0000,
                   {16'h0000, 16'h0000, 16'h8000, 16'h0000}, 1'b1);

        bus.i_ovf_clr_btrfly_ifft16 = 1'b1;
        tick();
        bus.i_ovf_clr_btrfly_ifft16 = 1'b0;
        chk("ovf_clr", 64'(bus.o_ovf_btrfly_ifft16), 64'd0);
        tick();
        chk("ovf_clr_stays", 64'(bus.o_ovf_btrfly_ifft16), 64'd0);

        // Backpressure: 8 pairs, downstream stalls during stream cycles 4..6
        idx_in  = 0;
        idx_out = 0;
        held    = '0;
        for (int cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
            bus.i_ready_btrfly_ifft16 = !(cyc >= 4 && cyc <= 6);
            if (idx_in < 8)
                drive(1'b1, 16'((idx_in + 1) * 256), 16'(-(idx_in * 64)),
                      16'h0000, 16'h0000, 16'h1000, 16'h0000);
            else
                bus.i_valid_btrfly_ifft16 = 1'b0;
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                chk("bp_ready_low", 64'(bus.o_ready_btrfly_ifft16), 64'd0);
                chk("bp_valid_held", 64'(bus.o_valid_btrfly_ifft16), 64'd1);
                if (cyc == 4) held = outs();
                else chk("bp_hold", outs(), held);
            end
            if (bus.o_valid_btrfly_ifft16 && bus.i_ready_btrfly_ifft16) begin
                chk($sformatf("bp_out%0d", idx_out), outs(), bp_exp(idx_out));
                idx_out++;
            end
            if (bus.i_valid_btrfly_ifft16 && bus.o_ready_btrfly_ifft16)
                idx_in++;
            tick();
        end
        bus.i_valid_btrfly_ifft16 = 1'b0;
        bus.i_ready_btrfly_ifft16 = 1'b1;
        chk("bp_count_out", 64'(idx_out), 64'd8);
        chk("bp_count_in",  64'(idx_in),  64'd8);
        tick();
        tick();
        chk("bp_no_dup", 64'(bus.o_valid_btrfly_ifft16), 64'd0);

        // Reset with pairs in flight (first one saturates, so ovf is set)
        drive(1'b1, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h2000, 16'h0000);
        tick();
        drive(1'b1, 16'h0800, 16'h0000, 16'h0400, 16'h0000, 16'h1000, 16'h0000);
        tick();
        drive(1'b1, 16'h0800, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 16'hF000);
        tick();
        chk("pre_rst_valid", 64'(bus.o_valid_btrfly_ifft16), 64'd1);
        chk("pre_rst_ovf",   64'(bus.o_ovf_btrfly_ifft16),   64'd1);
        rst = 1'b1;
        bus.i_valid_btrfly_ifft16 = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.o_valid_btrfly_ifft16), 64'd0);
        chk("mid_rst_ovf",   64'(bus.o_ovf_btrfly_ifft16),   64'd0);
        chk("mid_rst_data",  outs(), 64'd0);
        send_check("post_rst", 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h1000, 16'h0000,
                   {16'h0001, 16'h0000, 16'h0001, 16'h0000}, 1'b0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("post_rst_no_stale", 64'(bus.o_valid_btrfly_ifft16), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
